// File: rtl/ipv4_rx_parser.sv
// IPv4 receive parser: validates the header (version, IHL, length, protocol, destination,
// checksum), discards options and Ethernet padding, and forwards payload with one-cycle latency.
module ipv4_rx_parser #(
    parameter int unsigned              NUM_PROTO    = 2,
    parameter logic [NUM_PROTO*8-1:0]   PROTO_LIST   = 16'h1106,
    parameter logic [31:0]              IP_ADDRESS   = 32'hC0A8_0164,
    parameter bit                       ACCEPT_BCAST = 1'b1,
    parameter bit                       CHECK_CSUM   = 1'b1,
    localparam int unsigned             PW           = (NUM_PROTO > 1) ? $clog2(NUM_PROTO) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    eth_data_in,
    input  logic          eth_byte_valid,
    input  logic          eth_eof,
    input  logic          eth_err,
    output logic [7:0]    ip_data_out,
    output logic          ip_byte_valid,
    output logic          ip_eof,
    output logic          ip_err,
    output logic          ip_hdr_done,
    output logic [PW-1:0] ip_proto_idx,
    output logic [31:0]   ip_src_addr,
    output logic [15:0]   ip_payload_len
);

    typedef enum logic [1:0] {HEADER, PAYLOAD, PAD, FLUSH} state_t;

    state_t        state;
    logic [5:0]    hdr_cnt;
    logic [3:0]    ihl;
    logic [15:0]   csum;
    logic [7:0]    csum_hi;
    logic [15:0]   total_len;
    logic [15:0]   remaining;
    logic [31:0]   src_addr;
    logic          dst_uc_ok;
    logic          dst_bc_ok;
    logic [PW-1:0] proto_idx;

    logic [5:0]    hl;
    logic [16:0]   csum_sum;
    logic [15:0]   csum_next;
    logic          proto_hit;
    logic [PW-1:0] proto_match;
    logic [7:0]    ip_byte;
    logic          last_byte;
    logic          hdr_fail;
    logic [15:0]   payload_len;

    assign hl = {ihl, 2'b00};

    always_comb begin
        // One's-complement add with end-around carry folded back immediately
        csum_sum  = {1'b0, csum} + {1'b0, csum_hi, eth_data_in};
        csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};

        proto_hit   = 1'b0;
        proto_match = '0;
        for (int unsigned i = 0; i < NUM_PROTO; i++) begin
            if (!proto_hit && eth_data_in == PROTO_LIST[8*i +: 8]) begin
                proto_hit   = 1'b1;
                proto_match = PW'(i);
            end
        end

        case (hdr_cnt[1:0])
            2'd0:    ip_byte = IP_ADDRESS[31:24];
            2'd1:    ip_byte = IP_ADDRESS[23:16];
            2'd2:    ip_byte = IP_ADDRESS[15:8];
            default: ip_byte = IP_ADDRESS[7:0];
        endcase

        // HL is only known after byte 0; it is never below 20 once byte 0 passed
        last_byte   = (hdr_cnt >= 6'd19) && (hdr_cnt == hl - 6'd1);
        payload_len = total_len - {10'd0, hl};

        hdr_fail = 1'b0;
        case (hdr_cnt)
            6'd0:  hdr_fail = (eth_data_in[7:4] != 4'd4) || (eth_data_in[3:0] < 4'd5);
            6'd3:  hdr_fail = {total_len[15:8], eth_data_in} < {10'd0, hl};
            6'd9:  hdr_fail = !proto_hit;
            6'd19: hdr_fail = !((dst_uc_ok && eth_data_in == ip_byte) ||
                                (ACCEPT_BCAST && dst_bc_ok && eth_data_in == 8'hFF));
            default: ;
        endcase
        if (CHECK_CSUM && last_byte && csum_next != 16'hFFFF)
            hdr_fail = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HEADER;
            hdr_cnt        <= '0;
            ihl            <= '0;
            csum           <= '0;
            csum_hi        <= '0;
            total_len      <= '0;
            remaining      <= '0;
            src_addr       <= '0;
            dst_uc_ok      <= 1'b0;
            dst_bc_ok      <= 1'b0;
            proto_idx      <= '0;
            ip_data_out    <= '0;
            ip_byte_valid  <= 1'b0;
            ip_eof         <= 1'b0;
            ip_err         <= 1'b0;
            ip_hdr_done    <= 1'b0;
            ip_proto_idx   <= '0;
            ip_src_addr    <= '0;
            ip_payload_len <= '0;
        end else begin
            ip_byte_valid <= 1'b0;
            ip_eof        <= 1'b0;
            ip_err        <= 1'b0;
            ip_hdr_done   <= 1'b0;
            if (eth_byte_valid) begin
                case (state)
                    HEADER: begin
                        if (hdr_fail) begin
                            ip_eof  <= 1'b1;
                            ip_err  <= 1'b1;
                            hdr_cnt <= '0;
                            csum    <= '0;
                            state   <= eth_eof ? HEADER : FLUSH;
                        end else if (last_byte) begin
                            ip_hdr_done    <= 1'b1;
                            ip_proto_idx   <= proto_idx;
                            ip_src_addr    <= src_addr;
                            ip_payload_len <= payload_len;
                            remaining      <= payload_len;
                            hdr_cnt        <= '0;
                            csum           <= '0;
                            if (eth_eof) begin
                                // Frame ending on the header is only clean with no payload due
                                ip_eof <= 1'b1;
                                ip_err <= (payload_len != 16'd0) || eth_err;
                                state  <= HEADER;
                            end else begin
                                state <= (payload_len == 16'd0) ? PAD : PAYLOAD;
                            end
                        end else if (eth_eof) begin
                            ip_eof  <= 1'b1;
                            ip_err  <= 1'b1;
                            hdr_cnt <= '0;
                            csum    <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 6'd1;
                            if (hdr_cnt[0])
                                csum <= csum_next;
                            else
                                csum_hi <= eth_data_in;
                            case (hdr_cnt)
                                6'd0:  ihl              <= eth_data_in[3:0];
                                6'd2:  total_len[15:8]  <= eth_data_in;
                                6'd3:  total_len[7:0]   <= eth_data_in;
                                6'd9:  proto_idx        <= proto_match;
                                6'd12: src_addr[31:24]  <= eth_data_in;
                                6'd13: src_addr[23:16]  <= eth_data_in;
                                6'd14: src_addr[15:8]   <= eth_data_in;
                                6'd15: src_addr[7:0]    <= eth_data_in;
                                6'd16: begin
                                    dst_uc_ok <= (eth_data_in == ip_byte);
                                    dst_bc_ok <= (eth_data_in == 8'hFF);
                                end
                                6'd17, 6'd18: begin
                                    dst_uc_ok <= dst_uc_ok && (eth_data_in == ip_byte);
                                    dst_bc_ok <= dst_bc_ok && (eth_data_in == 8'hFF);
                                end
                                default: ;
                            endcase
                        end
                    end
                    PAYLOAD: begin
                        ip_byte_valid <= 1'b1;
                        ip_data_out   <= eth_data_in;
                        remaining     <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            if (eth_eof) begin
                                ip_eof <= 1'b1;
                                ip_err <= eth_err;
                                state  <= HEADER;
                            end else begin
                                state <= PAD;
                            end
                        end else if (eth_eof) begin
                            ip_eof <= 1'b1;
                            ip_err <= 1'b1;
                            state  <= HEADER;
                        end
                    end
                    PAD: begin
                        if (eth_eof) begin
                            ip_eof <= 1'b1;
                            ip_err <= eth_err;
                            state  <= HEADER;
                        end
                    end
                    default: begin
                        if (eth_eof)
                            state <= HEADER;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Bench for ipv4_rx_parser: directed frame table plus random frames, checked per byte
// against a frame-level model; a second instance runs with broadcast acceptance disabled.
`timescale 1ns/1ps
module tb_ipv4_rx_parser;

    localparam logic [31:0] MY_IP = 32'hC0A8_0164;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] d = '0;
    logic v = 1'b0, eof = 1'b0, err = 1'b0;

    logic [7:0] a_data, b_data;
    logic a_v, a_eof, a_err, a_hd, b_v, b_eof, b_err, b_hd;
    logic [0:0] a_idx, b_idx;
    logic [31:0] a_src, b_src;
    logic [15:0] a_plen, b_plen;

    ipv4_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .eth_data_in(d), .eth_byte_valid(v), .eth_eof(eof), .eth_err(err),
        .ip_data_out(a_data), .ip_byte_valid(a_v), .ip_eof(a_eof), .ip_err(a_err), .ip_hdr_done(a_hd),
        .ip_proto_idx(a_idx), .ip_src_addr(a_src), .ip_payload_len(a_plen));

    ipv4_rx_parser #(.ACCEPT_BCAST(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .eth_data_in(d), .eth_byte_valid(v), .eth_eof(eof), .eth_err(err),
        .ip_data_out(b_data), .ip_byte_valid(b_v), .ip_eof(b_eof), .ip_err(b_err), .ip_hdr_done(b_hd),
        .ip_proto_idx(b_idx), .ip_src_addr(b_src), .ip_payload_len(b_plen));

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [7:0] d; logic eof; logic err; logic hd;
        logic [0:0] idx; logic [31:0] src; logic [15:0] plen;
    } out_t;

    typedef struct {
        logic [3:0] ver; int ihl; int tl; logic [7:0] proto; logic [31:0] dst;
        int npay; int corrupt; int trunc; bit eerr;
        bit x_hd; int x_idx; int x_plen; int x_nout; bit x_err;
    } vec_t;

    int n_cmp = 0, n_bad = 0, frame_id = 0;
    logic [7:0] fq[$];
    bit cur_eerr;
    bit e_v[2][256], e_eof[2][256], e_err[2][256], e_hd[2][256];
    int e_idx, e_plen;
    logic [31:0] e_src;
    int cnt_out, cnt_eof, cap_idx, cap_plen;
    bit hd_seen, last_err;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s frame %0d: got %h want %h", name, frame_id, act, exp);
        end
    endtask

    function automatic out_t get_out(input int k);
        out_t o;
        if (k == 0) o = '{a_v, a_data, a_eof, a_err, a_hd, a_idx, a_src, a_plen};
        else        o = '{b_v, b_data, b_eof, b_err, b_hd, b_idx, b_src, b_plen};
        return o;
    endfunction

    function automatic logic [7:0] gb(input int j);
        return (j < fq.size()) ? fq[j] : 8'h00;
    endfunction

    task automatic build(input logic [3:0] ver, input int ihl, input int tl, input logic [7:0] proto,
                         input logic [31:0] src, input logic [31:0] dst, input int npay, input int corrupt);
        int hb;
        logic [31:0] s;
        hb = (ihl * 4 < 20) ? 20 : ihl * 4;
        fq.delete();
        for (int i = 0; i < hb; i++) fq.push_back(8'h00);
        fq[0] = {ver, ihl[3:0]};
        fq[2] = tl[15:8];  fq[3] = tl[7:0];
        fq[4] = 8'h12;     fq[5] = 8'h34;     fq[8] = 8'h40;  fq[9] = proto;
        fq[12] = src[31:24]; fq[13] = src[23:16]; fq[14] = src[15:8]; fq[15] = src[7:0];
        fq[16] = dst[31:24]; fq[17] = dst[23:16]; fq[18] = dst[15:8]; fq[19] = dst[7:0];
        for (int i = 20; i < hb; i++) fq[i] = 8'hA0 + 8'(i);
        s = 0;
        for (int i = 0; i < hb; i += 2) s += {16'd0, fq[i], fq[i+1]};
        while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        fq[10] = ~s[15:8];
        fq[11] = ~s[7:0];
        for (int i = 0; i < npay; i++) fq.push_back(8'(i + 1));
        if (corrupt >= 0) fq[corrupt] = fq[corrupt] ^ 8'h40;
    endtask

    // Frame-level reference: find the byte where the frame is decided, then lay out outputs
    task automatic model(input int k, input bit bcast);
        int n, ihl, hl, tl, fail, hdr_end, plen, last, pidx;
        logic [7:0] b0;
        logic [31:0] dst, s;
        bit pok;
        logic [7:0] plist[2];
        plist[0] = 8'h06; plist[1] = 8'h11;
        n = fq.size();
        last = n - 1;
        for (int j = 0; j < 256; j++) begin
            e_v[k][j] = 0; e_eof[k][j] = 0; e_err[k][j] = 0; e_hd[k][j] = 0;
        end
        b0 = gb(0);
        ihl = int'(b0[3:0]);
        hl = ihl * 4;
        tl = int'({gb(2), gb(3)});
        pok = 0; pidx = 0;
        for (int i = 0; i < 2; i++)
            if (!pok && gb(9) == plist[i]) begin pok = 1; pidx = i; end
        dst = {gb(16), gb(17), gb(18), gb(19)};
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'd0, gb(i), gb(i+1)};
        while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        fail = 1000;
        if (b0[7:4] != 4'd4 || ihl < 5)                      fail = 0;
        else if (tl < hl)                                    fail = 3;
        else if (!pok)                                       fail = 9;
        else if (!(dst == MY_IP || (bcast && dst == '1)))    fail = 19;
        else if (s[15:0] != 16'hFFFF)                        fail = hl - 1;
        hdr_end = (fail < 1000) ? fail : hl - 1;
        if (last < hdr_end) begin
            e_eof[k][last] = 1; e_err[k][last] = 1;
        end else if (fail < 1000) begin
            e_eof[k][fail] = 1; e_err[k][fail] = 1;
        end else begin
            plen = tl - hl;
            e_hd[k][hl-1] = 1;
            e_idx = pidx;
            e_src = {gb(12), gb(13), gb(14), gb(15)};
            e_plen = plen;
            for (int j = hl; j < hl + plen && j <= last; j++) e_v[k][j] = 1;
            e_eof[k][last] = 1;
            e_err[k][last] = (last < hl + plen - 1) ? 1'b1 : cur_eerr;
        end
    endtask

    task automatic check_out(input int k, input int j);
        out_t o;
        string p;
        o = get_out(k);
        p = $sformatf("dut%0d.", k);
        chk({p, "valid"}, 32'(o.v), 32'(e_v[k][j]));
        if (e_v[k][j]) chk({p, "data"}, 32'(o.d), 32'(fq[j]));
        chk({p, "eof"}, 32'(o.eof), 32'(e_eof[k][j]));
        chk({p, "err"}, 32'(o.err), 32'(e_err[k][j]));
        chk({p, "hdr_done"}, 32'(o.hd), 32'(e_hd[k][j]));
        if (e_hd[k][j]) begin
            chk({p, "proto_idx"}, 32'(o.idx), 32'(e_idx));
            chk({p, "src_addr"}, o.src, e_src);
            chk({p, "payload_len"}, 32'(o.plen), 32'(e_plen));
        end
        if (k == 0) begin
            if (o.v) cnt_out++;
            if (o.eof) begin cnt_eof++; last_err = o.err; end
            if (o.hd) begin hd_seen = 1; cap_idx = int'(o.idx); cap_plen = int'(o.plen); end
        end
    endtask

    task automatic step(input int j);
        @(negedge clk);
        v = 1'b1;
        d = fq[j];
        eof = (j == fq.size() - 1);
        err = eof ? cur_eerr : 1'($urandom);
        @(posedge clk);
        #1;
        check_out(0, j);
        check_out(1, j);
    endtask

    task automatic idle();
        out_t o;
        @(negedge clk);
        v = 1'b0; d = 8'($urandom); eof = 1'($urandom); err = 1'($urandom);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = get_out(k);
            chk($sformatf("dut%0d.idle_quiet", k), {28'd0, o.v, o.eof, o.err, o.hd}, 32'd0);
        end
    endtask

    task automatic send_frame(input bit eerr, input int max_gap);
        cur_eerr = eerr;
        model(0, 1'b1);
        model(1, 1'b0);
        cnt_out = 0; cnt_eof = 0; hd_seen = 0; last_err = 0; cap_idx = -1; cap_plen = -1;
        for (int j = 0; j < fq.size(); j++) begin
            repeat ($urandom_range(0, max_gap)) idle();
            step(j);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        out_t o;
        o = get_out(0);
        chk({tag, ".valid"}, 32'(o.v), 32'd0);
        chk({tag, ".data"}, 32'(o.d), 32'd0);
        chk({tag, ".eof"}, 32'(o.eof), 32'd0);
        chk({tag, ".err"}, 32'(o.err), 32'd0);
        chk({tag, ".hdr_done"}, 32'(o.hd), 32'd0);
        chk({tag, ".proto_idx"}, 32'(o.idx), 32'd0);
        chk({tag, ".src_addr"}, o.src, 32'd0);
        chk({tag, ".payload_len"}, 32'(o.plen), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           ver  ihl tl  proto  dst              npay corr trunc eerr  hd idx plen nout err
        tbl[0]  = '{4'd4, 5, 28, 8'h11, MY_IP,             8, -1, -1, 1'b0, 1, 1, 8,  8,  0};
        tbl[1]  = '{4'd4, 5, 30, 8'h11, MY_IP,            26, -1, -1, 1'b0, 1, 1, 10, 10, 0};
        tbl[2]  = '{4'd4, 5, 30, 8'h11, MY_IP,            26, -1, -1, 1'b1, 1, 1, 10, 10, 1};
        tbl[3]  = '{4'd4, 6, 30, 8'h06, MY_IP,             6, -1, -1, 1'b0, 1, 0, 6,  6,  0};
        tbl[4]  = '{4'd4, 5, 28, 8'h11, MY_IP,             8, 10, -1, 1'b0, 0, 0, 0,  0,  1};
        tbl[5]  = '{4'd4, 5, 24, 8'h06, MY_IP,             4, -1, -1, 1'b0, 1, 0, 4,  4,  0};
        tbl[6]  = '{4'd4, 5, 28, 8'h01, MY_IP,             8, -1, -1, 1'b0, 0, 0, 0,  0,  1};
        tbl[7]  = '{4'd4, 5, 22, 8'h11, 32'hFFFF_FFFF,     2, -1, -1, 1'b0, 1, 1, 2,  2,  0};
        tbl[8]  = '{4'd4, 5, 28, 8'h11, MY_IP,             8, -1, 13, 1'b0, 0, 0, 0,  0,  1};
        tbl[9]  = '{4'd4, 5, 20, 8'h06, MY_IP,             0, -1, -1, 1'b0, 1, 0, 0,  0,  0};
        tbl[10] = '{4'd4, 5, 20, 8'h11, MY_IP,             6, -1, -1, 1'b1, 1, 1, 0,  0,  1};
        tbl[11] = '{4'd6, 5, 28, 8'h11, MY_IP,             8, -1, -1, 1'b0, 0, 0, 0,  0,  1};
        tbl[12] = '{4'd4, 5, 10, 8'h11, MY_IP,             8, -1, -1, 1'b0, 0, 0, 0,  0,  1};
        tbl[13] = '{4'd4, 5, 40, 8'h11, MY_IP,             5, -1, -1, 1'b0, 1, 1, 20, 5,  1};
        tbl[14] = '{4'd4, 5, 28, 8'h11, MY_IP ^ 32'd1,     8, -1, -1, 1'b0, 0, 0, 0,  0,  1};
        tbl[15] = '{4'd4, 8, 40, 8'h11, MY_IP,             8, -1, -1, 1'b0, 1, 1, 8,  8,  0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 16; t++) begin
            frame_id = t;
            build(tbl[t].ver, tbl[t].ihl, tbl[t].tl, tbl[t].proto, 32'h0A00_0001 + 32'(t),
                  tbl[t].dst, tbl[t].npay, tbl[t].corrupt);
            if (tbl[t].trunc > 0) while (fq.size() > tbl[t].trunc) void'(fq.pop_back());
            send_frame(tbl[t].eerr, 0);
            chk("tbl.eof_count", 32'(cnt_eof), 32'd1);
            chk("tbl.hdr_done", 32'(hd_seen), 32'(tbl[t].x_hd));
            chk("tbl.bytes_out", 32'(cnt_out), 32'(tbl[t].x_nout));
            chk("tbl.eof_err", 32'(last_err), 32'(tbl[t].x_err));
            if (tbl[t].x_hd) begin
                chk("tbl.proto_idx", 32'(cap_idx), 32'(tbl[t].x_idx));
                chk("tbl.payload_len", 32'(cap_plen), 32'(tbl[t].x_plen));
            end
        end

        // Reset in the middle of a payload, then a clean frame
        frame_id = 100;
        build(4'd4, 5, 40, 8'h11, 32'h0A0B_0C0D, MY_IP, 20, -1);
        cur_eerr = 1'b0;
        model(0, 1'b1);
        model(1, 1'b0);
        for (int j = 0; j < 24; j++) step(j);
        #2;
        rst_n = 1'b0;
        v = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        frame_id = 101;
        build(4'd4, 5, 28, 8'h11, 32'h0A00_0009, MY_IP, 8, -1);
        send_frame(1'b0, 1);
        chk("postreset.bytes_out", 32'(cnt_out), 32'd8);
        chk("postreset.hdr_done", 32'(hd_seen), 32'd1);

        for (int r = 0; r < 200; r++) begin
            logic [3:0] ver;
            logic [7:0] proto;
            logic [31:0] dst;
            int ihl, hl, tl, npay, corrupt, hb;
            frame_id = 1000 + r;
            ver = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'd4;
            ihl = ($urandom_range(0, 15) < 12) ? 5 : int'($urandom_range(3, 9));
            hl = ihl * 4;
            hb = (hl < 20) ? 20 : hl;
            case ($urandom_range(0, 4))
                0: proto = 8'h06;
                1, 2: proto = 8'h11;
                3: proto = 8'h01;
                default: proto = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1: dst = MY_IP;
                2: dst = 32'hFFFF_FFFF;
                default: dst = $urandom;
            endcase
            tl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 60)) : hl + int'($urandom_range(0, 20));
            npay = int'($urandom_range(0, 24));
            corrupt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, hb - 1)) : -1;
            build(ver, ihl, tl, proto, $urandom, dst, npay, corrupt);
            if ($urandom_range(0, 9) == 0) begin
                int keep;
                keep = int'($urandom_range(1, fq.size()));
                while (fq.size() > keep) void'(fq.pop_back());
            end
            send_frame(1'($urandom_range(0, 3) == 0), 2);
            chk("rand.eof_count", 32'(cnt_eof), 32'd1);
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
